// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic-cycle initiator: valid/ready command in, valid/ready response out.
// Optional watchdog abort is compiled in with WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    // Command and response streams: a transfer happens on any clock edge where valid && ready.
    // Once valid is raised by the producer it holds its payload until ready is seen.
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TO_W) - 1) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYCLES does not fit in TO_W bits");
    end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over a watchdog expiry in the same cycle.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                    rsp_valid_d = 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: vector table, corner sequences and random transactions
// against a transaction-level model; timeout cases depend on WB_CMD_MASTER_TIMEOUT_EN.
module tb_wb_cmd_master;

    localparam int TO = 16;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        wb_rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    logic [32:0] exp_q[$];

    wb_cmd_master #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_n(wb_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one response per command; abort only once the wait reaches the limit.
    function automatic logic [32:0] model_rsp(input logic we, input int ack_wait, input logic [31:0] rd);
        if (TO_EN && ack_wait >= TO) return {1'b1, 32'h0};
        return {1'b0, (we ? 32'h0 : rd)};
    endfunction

    function automatic int model_len(input int ack_wait);
        if (TO_EN && ack_wait >= TO) return TO;
        return ack_wait + 1;
    endfunction

    // Driver: issue one command, act as responder acking after ack_wait idle BUS cycles,
    // then consume the response after ready_wait backpressure cycles.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int ack_wait, input logic [31:0] rd,
                          input int ready_wait, input int exp_len, output int t_hs);
        logic [32:0] held;
        int k;
        bit done;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        t_hs = cyc_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        k = 0;
        done = 1'b0;
        while (!done && k < 300) begin
            chk("bus_hold", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, busy, cmd_ready},
                {1'b1, 1'b1, we, sel, adr, dat, 1'b1, 1'b0});
            wbm_ack_i = (k == ack_wait);
            wbm_dat_i = (k == ack_wait) ? rd : $urandom;
            @(posedge clk); #1;
            k++;
            if (!wbm_cyc_o) done = 1'b1;
        end
        wbm_ack_i = 1'b0;
        chk("bus_len", k, exp_len);
        chk("rsp_rise", {wbm_stb_o, rsp_valid}, 2'b01);
        held = {rsp_err, rsp_dat};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: got response %0h expected none", held);
        end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if (held !== e) begin
                failures++;
                $display("FAIL rsp_data: got %0h expected %0h", held, e);
            end
        end
        for (int w = 0; w < ready_wait; w++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            wbm_ack_i = 1'($urandom_range(0, 1));
            wbm_dat_i = $urandom;
            @(posedge clk); #1;
            chk("bp_hold", {rsp_valid, rsp_err, rsp_dat}, {1'b1, held});
            chk("bp_no_accept", {cmd_ready, busy, wbm_cyc_o, wbm_stb_o}, 4'b0100);
        end
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_done", {rsp_valid, cmd_ready, busy, wbm_cyc_o}, 4'b0100);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_wait;
        logic [31:0] rd;
        int          ready_wait;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t1, t2;
        vecs[0] = '{1'b1, 32'h3000_0000, 32'h0005_0003, 4'hF, 1,  32'hDEAD_BEEF, 0, 1'b0, 32'h0,         2};
        vecs[1] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1,  32'h0000_0008, 0, 1'b0, 32'h0000_0008, 2};
        vecs[2] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 0,  32'h1234_5678, 5, 1'b0, 32'h1234_5678, 1};
        vecs[3] = '{1'b1, 32'h3000_000C, 32'hA5A5_5A5A, 4'h3, 3,  32'hFFFF_FFFF, 2, 1'b0, 32'h0,         4};
        vecs[4] = '{1'b0, 32'h3000_0010, 32'h0,         4'h1, 15, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D, 16};
        vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h8, 2,  32'h0,         0, 1'b0, 32'h0,         3};

        wb_rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vals", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
            {1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_dat, cmd_ready, busy}, {1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        @(negedge clk) wb_rst_n = 1'b1;
        @(posedge clk); #1;

        // Ack while idle must be ignored
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h1111_2222;
        @(posedge clk); #1;
        wbm_ack_i = 1'b0;
        chk("idle_ack_ignored", {rsp_valid, wbm_cyc_o, cmd_ready, busy, rsp_dat}, {1'b0, 1'b0, 1'b1, 1'b0, 32'h0});

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({vecs[i].exp_err, vecs[i].exp_dat});
            do_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].ack_wait,
                   vecs[i].rd, vecs[i].ready_wait, vecs[i].exp_len, t1);
        end

        // Back-to-back registered-ack transactions: 4 cycles each
        exp_q.push_back({1'b0, 32'h0});
        do_txn(1'b1, 32'h3000_0020, 32'h0000_0042, 4'hF, 1, 32'h0, 0, 2, t1);
        exp_q.push_back({1'b0, 32'h0000_0077});
        do_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 1, 32'h0000_0077, 0, 2, t2);
        chk("throughput", t2 - t1, 4);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        // No ack: abort after exactly TO cycles, late acks in RESP ignored
        exp_q.push_back({1'b1, 32'h0});
        do_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 30, 32'h5555_AAAA, 3, TO, t1);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h9999_0000;
        @(posedge clk); #1;
        wbm_ack_i = 1'b0;
        chk("late_ack_ignored", {rsp_valid, wbm_cyc_o, busy}, 3'b000);
`else
        // Without the watchdog a slow responder is simply waited on
        exp_q.push_back({1'b0, 32'h0BAD_F00D});
        do_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 40, 32'h0BAD_F00D, 1, 41, t1);
`endif

        // Asynchronous reset two cycles into BUS
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_bus", {wbm_cyc_o, wbm_stb_o}, 2'b11);
        #2 wb_rst_n = 1'b0;
        #1;
        chk("async_reset_drop", {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, busy}, 5'b00010);
        @(posedge clk); #1;
        @(negedge clk) wb_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", {wbm_cyc_o, rsp_valid, cmd_ready, busy, wbm_adr_o}, {4'b0010, 32'h0});
        exp_q.push_back({1'b0, 32'h0000_00AB});
        do_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'h0000_00AB, 0, 2, t1);

        // Random transactions against the model
        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [31:0] adr, dat, rd;
            logic [3:0]  sel;
            int          aw, rw;
            we  = 1'($urandom_range(0, 1));
            adr = $urandom; dat = $urandom; rd = $urandom;
            sel = 4'($urandom_range(1, 15));
            aw  = TO_EN ? $urandom_range(0, 20) : $urandom_range(0, 6);
            rw  = $urandom_range(0, 3);
            exp_q.push_back(model_rsp(we, aw, rd));
            do_txn(we, adr, dat, sel, aw, rd, rw, model_len(aw), t1);
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
